systolic_array: RTL
===================

Name: systolic_array

Overview:
- Sits directly downstream of the zero-padding stages for operands A and B.
- Consumes the skewed lane vectors they stream: vectorA holds one lane per row of A, vectorB one lane per column of B.
- Computes C = A x B in a max_dim x max_dim grid of multiply-accumulate cells.
- Drains C one row per cycle onto a bus_width-wide output for write-back.

Parameters:
- data_width, 32, width of one matrix element and of each accumulator.
- bus_width, 64, width of the row output; max_dim = bus_width/data_width is a derived localparam, not overridable.

Ports:
- clk, input, 1, single clock; all state changes on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- done, input, 1, synchronous clear; returns the block to IDLE.
- in_valid, input, 1, qualifies vectorA/vectorB this cycle; driven by done_paddign_A AND done_paddign_B.
- vectorA, input, data_width*max_dim, lane i = next element entering row i from the left.
- vectorB, input, data_width*max_dim, lane j = next element entering column j from the top.
- c_row, output, bus_width, drained row of C; lane j at [data_width*(j+1)-1:data_width*j] = C[r][j].
- c_row_valid, output, 1, c_row and c_row_idx are valid this cycle.
- c_row_idx, output, clog2(max_dim) (minimum 1), row index r of c_row.
- busy, output, 1, high in STREAM, FLUSH and DRAIN.
- result_done, output, 1, level; high in DONE until done or reset.
- overflow, output, 1, sticky; set when any accumulate exceeds the signed data_width range.

Behaviour:
- Reset (reset low, asynchronous):
  - All outputs 0.
  - All accumulators and pipeline registers 0.
  - State IDLE.
- Cell(i,j), on each advance:
  - acc += a_in*b_in (signed two's complement).
  - Registers a_in to the right neighbour and b_in to the lower neighbour.
  - Row-0 cells take b from vectorB; column-0 cells take a from vectorA.
- Arithmetic:
  - Product is computed at full 2*data_width.
  - Accumulator holds data_width bits and keeps the low data_width bits of the exact sum (wrap).
  - overflow is set if the exact sum falls outside [-2^(dw-1), 2^(dw-1)-1].
- Advance conditions:
  - STREAM: array advances only on cycles with in_valid=1. in_valid=0 is a bubble: no shift, no accumulate.
  - FLUSH: array advances every cycle with zero injected at both edges.
- State machine:
  - IDLE -> STREAM on the first in_valid=1. That beat is accepted as beat 0.
  - STREAM: counts accepted beats. After beat 2*max_dim-2 is accepted, go to FLUSH.
  - FLUSH: lasts max_dim-1 cycles, then DRAIN. At the end of FLUSH every cell holds its final value (last product lands 3*max_dim-3 advances after beat 0).
  - DRAIN: max_dim cycles. Row r=0..max_dim-1 is presented one per cycle with c_row_valid=1 and c_row_idx=r. No back-pressure. Then go to DONE.
  - DONE: result_done=1, c_row_valid=0. in_valid is ignored. Stays here until done=1.
- done=1 in any state (takes priority over in_valid):
  - Next cycle state is IDLE.
  - Accumulators, beat counter, c_row, c_row_valid, result_done and overflow are cleared.
  - A done arriving mid-STREAM or mid-DRAIN aborts the operation; no partial rows follow.
- in_valid during FLUSH or DRAIN is ignored; it is not queued.
- Latency: the first c_row_valid occurs max_dim cycles after the last accepted beat.

Optional Feature:
- SYSTOLIC_SAT_EN defined: each accumulate clamps to 2^(dw-1)-1 or -2^(dw-1) on overflow.
- SYSTOLIC_SAT_EN undefined: accumulate wraps.
- overflow is set identically in both builds.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, STREAM, FLUSH, DRAIN, DONE);
  - localparams max_dim, BEATS = 2*max_dim-1 and FLUSH_CYC = max_dim-1;
  - signed max/min constants for data_width.
- One natural sub-module: systolic_pe (one MAC cell), instantiated max_dim*max_dim times by generate. Inputs: advance, clear, a_in, b_in. Outputs: a_out, b_out, acc, ovf.

Test Plan (data_width=32, bus_width=64, max_dim=2):
- Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]] streamed as 3 consecutive beats (vectorA {lane1,lane0}: {0,1},{3,2},{4,0}; vectorB: {0,5},{6,7},{8,0}). Expected: DRAIN gives c_row={22,19}, idx0, then {50,43}, idx1; first valid 2 cycles after beat 2; then result_done=1; overflow=0.
- Bubbles: same data with in_valid low for 2 cycles between beats 0 and 1 and between beats 1 and 2. Expected: identical rows, delayed by 4 cycles.
- Signed values: A=[[-1,2],[3,-4]], B=identity. Expected: rows {2,-1} and {-4,3}.
- Overflow: A00=B00=0x7FFFFFFF, others 0. Expected: overflow=1. C00 wraps to 0x00000001 without SYSTOLIC_SAT_EN and clamps to 0x7FFFFFFF with it.
- Abort: done pulsed after beat 1. Expected: IDLE next cycle; no c_row_valid. A fresh basic-multiply run then gives the correct C with no residue.
- Async reset: reset low mid-DRAIN, asserted away from any clk edge. Expected: all outputs 0 immediately; after release, in_valid starts a new run normally.

Source files
------------

// File: rtl/systolic_array_pkg.sv
// Shared definitions for the systolic matrix-multiply block: controller
// state encoding, default geometry and the signed accumulator limits.
package systolic_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STREAM = 3'd1,
        S_FLUSH  = 3'd2,
        S_DRAIN  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int DATA_WIDTH = 32;
    localparam int BUS_WIDTH  = 64;
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int BEATS      = 2 * MAX_DIM - 1;
    localparam int FLUSH_CYC  = MAX_DIM - 1;

    localparam logic [DATA_WIDTH-1:0] ACC_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] ACC_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    // Number of skewed input beats needed for an md x md product.
    function automatic int beats_for(input int md);
        return 2 * md - 1;
    endfunction

    // Extra zero-injection advances needed after the last beat.
    function automatic int flush_for(input int md);
        return md - 1;
    endfunction

endpackage

// File: rtl/systolic_array_if.sv
// Stream-in / row-out bundle of the systolic array. The producer side
// (padding stages + write-back) uses master, the array uses slave.
interface systolic_array_if #(
    parameter int data_width = 32,
    parameter int bus_width  = 64
);
    localparam int max_dim = bus_width / data_width;
    localparam int idx_w   = (max_dim > 1) ? $clog2(max_dim) : 1;

    logic                          done;
    logic                          in_valid;
    logic [data_width*max_dim-1:0] vectorA;
    logic [data_width*max_dim-1:0] vectorB;
    logic [bus_width-1:0]          c_row;
    logic                          c_row_valid;
    logic [idx_w-1:0]              c_row_idx;
    logic                          busy;
    logic                          result_done;
    logic                          overflow;

    modport master (
        output done, in_valid, vectorA, vectorB,
        input  c_row, c_row_valid, c_row_idx, busy, result_done, overflow
    );

    modport slave (
        input  done, in_valid, vectorA, vectorB,
        output c_row, c_row_valid, c_row_idx, busy, result_done, overflow
    );
endinterface

// File: rtl/systolic_pe.sv
// One multiply-accumulate cell of the systolic grid. Passes a to the right
// and b downward one advance later, accumulates a*b in data_width bits.
// Build option SYSTOLIC_SAT_EN: clamp the accumulator on overflow instead
// of wrapping; the ovf flag is raised the same way in both builds.
module systolic_pe #(
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  advance,
    input  logic                  clear,
    input  logic [data_width-1:0] a_in,
    input  logic [data_width-1:0] b_in,
    output logic [data_width-1:0] a_out,
    output logic [data_width-1:0] b_out,
    output logic [data_width-1:0] acc,
    output logic                  ovf
);
    localparam int pw = 2 * data_width;

    logic [pw-1:0]         a_ext_s;
    logic [pw-1:0]         b_ext_s;
    logic [pw-1:0]         prod_s;
    logic [pw:0]           sum_s;
    logic [data_width+1:0] sum_top_s;
    logic                  range_ovf_s;
    logic [data_width-1:0] acc_nxt_s;

`ifdef SYSTOLIC_SAT_EN
    localparam logic [data_width-1:0] sat_max_c = {1'b0, {(data_width-1){1'b1}}};
    localparam logic [data_width-1:0] sat_min_c = {1'b1, {(data_width-1){1'b0}}};
`endif

    // Exact signed product and sum; the sum is in range only when all bits
    // from the sign position of data_width upward agree.
    always_comb begin
        a_ext_s     = {{data_width{a_in[data_width-1]}}, a_in};
        b_ext_s     = {{data_width{b_in[data_width-1]}}, b_in};
        prod_s      = a_ext_s * b_ext_s;
        sum_s       = {{(data_width+1){acc[data_width-1]}}, acc} + {prod_s[pw-1], prod_s};
        sum_top_s   = sum_s[pw:data_width-1];
        range_ovf_s = !((&sum_top_s) || (~|sum_top_s));
`ifdef SYSTOLIC_SAT_EN
        if (range_ovf_s) begin
            acc_nxt_s = sum_s[pw] ? sat_min_c : sat_max_c;
        end else begin
            acc_nxt_s = sum_s[data_width-1:0];
        end
`else
        acc_nxt_s = sum_s[data_width-1:0];
`endif
    end

    assign ovf = advance & range_ovf_s;

    // Accumulator and neighbour pipeline registers; clear wins over advance.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (clear) begin
            acc   <= '0;
            a_out <= '0;
            b_out <= '0;
        end else if (advance) begin
            acc   <= acc_nxt_s;
            a_out <= a_in;
            b_out <= b_in;
        end
    end
endmodule

// File: rtl/systolic_array.sv
// Output-stationary systolic array computing C = A x B from skewed lane
// vectors, then draining C one row per cycle.
// Build option SYSTOLIC_SAT_EN: saturating accumulators (see systolic_pe).
module systolic_array
    import systolic_array_pkg::*;
#(
    parameter int data_width = 32,
    parameter int bus_width  = 64
) (
    input  logic             clk,
    input  logic             reset,
    systolic_array_if.slave  bus
);
    localparam int max_dim = bus_width / data_width;
    localparam int beats_c = beats_for(max_dim);
    localparam int flush_c = flush_for(max_dim);
    localparam int idx_w   = (max_dim > 1) ? $clog2(max_dim) : 1;
    localparam int cnt_w   = $clog2(beats_c + 1);

    localparam logic [cnt_w-1:0] last_beat_c  = cnt_w'(beats_c - 1);
    localparam logic [cnt_w-1:0] last_flush_c = cnt_w'(flush_c - 1);
    localparam logic [cnt_w-1:0] last_row_c   = cnt_w'(max_dim - 1);
    localparam logic [cnt_w-1:0] one_c        = cnt_w'(1);

    state_t           state_r, state_n;
    logic [cnt_w-1:0] cnt_r, cnt_n;
    logic             advance_s;
    logic             flush_s;
    logic             any_ovf_s;
    logic [bus_width-1:0] row_s;

    logic             busy_r, c_row_valid_r, result_done_r, overflow_r;
    logic [idx_w-1:0] c_row_idx_r;

    logic [data_width-1:0] a_pipe_s [max_dim][max_dim+1];
    logic [data_width-1:0] b_pipe_s [max_dim+1][max_dim];
    logic [data_width-1:0] acc_s    [max_dim][max_dim];
    logic                  ovf_s    [max_dim][max_dim];

    // Edge injection: live lanes while streaming, zeros while flushing.
    for (genvar i = 0; i < max_dim; i++) begin : g_edge
        assign a_pipe_s[i][0] = flush_s ? '0 : bus.vectorA[i*data_width +: data_width];
        assign b_pipe_s[0][i] = flush_s ? '0 : bus.vectorB[i*data_width +: data_width];
    end

    for (genvar i = 0; i < max_dim; i++) begin : g_row
        for (genvar j = 0; j < max_dim; j++) begin : g_col
            systolic_pe #(.data_width(data_width)) u_pe (
                .clk     (clk),
                .reset   (reset),
                .advance (advance_s),
                .clear   (bus.done),
                .a_in    (a_pipe_s[i][j]),
                .b_in    (b_pipe_s[i][j]),
                .a_out   (a_pipe_s[i][j+1]),
                .b_out   (b_pipe_s[i+1][j]),
                .acc     (acc_s[i][j]),
                .ovf     (ovf_s[i][j])
            );
        end
    end

    // Controller next state: beat counting, flush length, drain row count.
    always_comb begin
        state_n   = state_r;
        cnt_n     = cnt_r;
        advance_s = 1'b0;
        flush_s   = 1'b0;
        if (bus.done) begin
            state_n = S_IDLE;
            cnt_n   = '0;
        end else begin
            case (state_r)
                S_IDLE, S_STREAM: begin
                    if (bus.in_valid) begin
                        advance_s = 1'b1;
                        if (cnt_r == last_beat_c) begin
                            state_n = (flush_c == 0) ? S_DRAIN : S_FLUSH;
                            cnt_n   = '0;
                        end else begin
                            state_n = S_STREAM;
                            cnt_n   = cnt_r + one_c;
                        end
                    end else begin
                        state_n = state_r;
                    end
                end
                S_FLUSH: begin
                    advance_s = 1'b1;
                    flush_s   = 1'b1;
                    if (cnt_r == last_flush_c) begin
                        state_n = S_DRAIN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_r + one_c;
                    end
                end
                S_DRAIN: begin
                    if (cnt_r == last_row_c) begin
                        state_n = S_DONE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_r + one_c;
                    end
                end
                S_DONE: begin
                    state_n = S_DONE;
                end
                default: begin
                    state_n = S_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Controller state and counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= S_IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
        end
    end

    // OR of every cell's overflow for this advance.
    always_comb begin
        any_ovf_s = 1'b0;
        for (int i = 0; i < max_dim; i++) begin
            for (int j = 0; j < max_dim; j++) begin
                any_ovf_s = any_ovf_s | ovf_s[i][j];
            end
        end
    end

    // Status outputs, registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_r        <= 1'b0;
            c_row_valid_r <= 1'b0;
            c_row_idx_r   <= '0;
            result_done_r <= 1'b0;
            overflow_r    <= 1'b0;
        end else begin
            busy_r        <= (state_n == S_STREAM) || (state_n == S_FLUSH) || (state_n == S_DRAIN);
            c_row_valid_r <= (state_n == S_DRAIN);
            c_row_idx_r   <= (state_n == S_DRAIN) ? cnt_n[idx_w-1:0] : '0;
            result_done_r <= (state_n == S_DONE);
            overflow_r    <= bus.done ? 1'b0 : (overflow_r | any_ovf_s);
        end
    end

    // Row select: the last flush advance lands on the same edge that opens
    // DRAIN, so rows are read straight from the accumulators.
    always_comb begin
        row_s = '0;
        for (int j = 0; j < max_dim; j++) begin
            row_s[j*data_width +: data_width] = acc_s[c_row_idx_r][j];
        end
    end

    assign bus.c_row       = c_row_valid_r ? row_s : '0;
    assign bus.c_row_valid = c_row_valid_r;
    assign bus.c_row_idx   = c_row_idx_r;
    assign bus.busy        = busy_r;
    assign bus.result_done = result_done_r;
    assign bus.overflow    = overflow_r;
endmodule
